down_cntr_timer: RTL and testbench

- Loadable down-counter with terminal-count pulse. It is the count-down counterpart to the team's up-counter.
- The counter is loaded with a value N. It then counts to zero, one step per enabled clock, and flags expiry.
- One-shot and periodic (auto-reload) modes are supported.
- Used as a programmable interval/timeout source next to the up-counter in the same datapath.

---
 rtl/down_cntr_timer_if.sv | 33 +++
 rtl/down_cntr_timer.sv | 74 +++++++
 tb/tb_down_cntr_timer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/down_cntr_timer_if.sv
// Control/status bundle for the down-counter timer.
// master drives load/enable/mode, slave (the timer) returns count, tc and busy.
interface down_cntr_timer_if #(
   parameter int COUNT_WIDTH = 4
);
   logic                   en;
   logic                   load;
   logic [COUNT_WIDTH-1:0] load_val;
   logic                   mode;
   logic [COUNT_WIDTH-1:0] count;
   logic                   tc;
   logic                   busy;

   modport master (
      output en,
      output load,
      output load_val,
      output mode,
      input  count,
      input  tc,
      input  busy
   );

   modport slave (
      input  en,
      input  load,
      input  load_val,
      input  mode,
      output count,
      output tc,
      output busy
   );
endinterface

// File: rtl/down_cntr_timer.sv
// Loadable down-counter with one-clock terminal-count pulse, one-shot or periodic reload.
// All outputs registered, one clock after the causing edge; no backpressure, en only gates decrement.
module down_cntr_timer #(
   parameter int COUNT_WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   down_cntr_timer_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [COUNT_WIDTH-1:0] reload_q, reload_d;
   logic                   tc_q, tc_d;
   logic                   busy_q, busy_d;

   localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = '0;
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      tc_d     = 1'b0;

      if (bus.load) begin
         // A load always wins over a terminal event in the same cycle.
         count_d  = bus.load_val;
         reload_d = bus.load_val;
         state_d  = (bus.load_val != CNT_ZERO) ? RUN : IDLE;
      end else if (state_q == RUN && bus.en) begin
         if (count_q == CNT_ONE) begin
            tc_d = 1'b1;
            if (bus.mode) begin
               count_d = reload_q;
            end else begin
               count_d = CNT_ZERO;
               state_d = DONE;
            end
         end else begin
            count_d = count_q - CNT_ONE;
         end
      end

      busy_d = (state_d == RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         tc_q     <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.count = count_q;
   assign bus.tc    = tc_q;
   assign bus.busy  = busy_q;

endmodule

// File: tb/tb_down_cntr_timer.sv
// Self-checking bench for down_cntr_timer: directed scenarios then random traffic
// against an elapsed-cycles reference model.
module tb_down_cntr_timer;

   localparam int CW = 4;

   logic clk;
   logic rst;

   down_cntr_timer_if #(.COUNT_WIDTH(CW)) bus ();

   down_cntr_timer #(.COUNT_WIDTH(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int tc_seen = 0;

   // Reference: period N, enabled cycles elapsed k, running flag.
   int m_n   = 0;
   int m_k   = 0;
   bit m_run = 1'b0;
   bit m_tc  = 1'b0;

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick(input bit r, input bit e, input bit l, input int lv, input bit m);
      int exp_count;
      rst          = r;
      bus.en       = e;
      bus.load     = l;
      bus.load_val = CW'(lv);
      bus.mode     = m;
      @(posedge clk);
      m_tc = 1'b0;
      if (r) begin
         m_run = 1'b0;
         m_n   = 0;
         m_k   = 0;
      end else if (l) begin
         m_n   = lv;
         m_k   = 0;
         m_run = (lv != 0);
      end else if (m_run && e) begin
         m_k++;
         if (m_k == m_n) begin
            m_tc = 1'b1;
            m_k  = 0;
            if (!m) m_run = 1'b0;
         end
      end
      exp_count = m_run ? (m_n - m_k) : 0;
      #1;
      check("count", int'(bus.count), exp_count);
      check("tc",    int'(bus.tc),    int'(m_tc));
      check("busy",  int'(bus.busy),  int'(m_run));
      if (bus.tc) tc_seen++;
   endtask

   initial begin
      int n;
      rst          = 1'b1;
      bus.en       = 1'b0;
      bus.load     = 1'b0;
      bus.load_val = '0;
      bus.mode     = 1'b0;

      // Reset, then one-shot of 5 with 10 idle cycles after expiry.
      tick(1, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0);
      check("reset_count", int'(bus.count), 0);
      tc_seen = 0;
      tick(0, 1, 1, 5, 0);
      check("oneshot_load", int'(bus.count), 5);
      for (int i = 0; i < 15; i++) tick(0, 1, 0, 0, 0);
      check("oneshot_tc_count", tc_seen, 1);

      // Periodic reload of 3 for 12 enabled cycles.
      tc_seen = 0;
      tick(0, 1, 1, 3, 1);
      for (int i = 0; i < 12; i++) tick(0, 1, 0, 0, 1);
      check("periodic_tc_count", tc_seen, 4);

      // Enable gating: en toggling 1,0,1,0,...
      tc_seen = 0;
      tick(0, 0, 1, 4, 0);
      for (int i = 0; i < 8; i++) tick(0, (i % 2) == 0, 0, 0, 0);
      check("gated_tc_count", tc_seen, 1);

      // Load arriving on the terminal cycle cancels the pulse.
      tc_seen = 0;
      tick(0, 1, 1, 6, 0);
      for (int i = 0; i < 5; i++) tick(0, 1, 0, 0, 0);
      check("prio_pre_count", int'(bus.count), 1);
      tick(0, 1, 1, 2, 0);
      check("prio_tc_cancel", int'(bus.tc), 0);
      check("prio_reload", int'(bus.count), 2);
      tick(0, 1, 0, 0, 0);
      tick(0, 1, 0, 0, 0);
      check("prio_tc_count", tc_seen, 1);

      // Zero load never produces tc.
      tc_seen = 0;
      tick(0, 1, 1, 0, 1);
      for (int i = 0; i < 20; i++) tick(0, 1, 0, 0, 1);
      check("zero_tc_count", tc_seen, 0);

      // Max load: tc after exactly 15 enabled cycles.
      tick(0, 1, 1, 15, 0);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         tick(0, 1, 0, 0, 0);
         n++;
         if (bus.tc) break;
      end
      check("max_tc_cycles", n, 15);

      // Mid-count reset clears everything; enable alone does not restart.
      tick(0, 1, 1, 9, 0);
      for (int i = 0; i < 4; i++) tick(0, 1, 0, 0, 0);
      tick(1, 1, 0, 0, 0);
      check("midrst_count", int'(bus.count), 0);
      for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 1);
      check("midrst_busy", int'(bus.busy), 0);

      // Random traffic.
      for (int i = 0; i < 800; i++) begin
         tick(($urandom_range(0, 59) == 0),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 9) == 0),
              int'($urandom_range(0, 15)),
              bit'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
